// File: rtl/elevator_timer_if.sv
// Elevator timer bus: controller commands in, timer status out.
interface elevator_timer_if #(
  parameter int CW = 7
);
  logic          StRun;
  logic          StOpen;
  logic          delay;
  logic          close;
  logic          obstruct;
  logic [CW-1:0] count;
  logic [1:0]    dispStage;
  logic          endRun;
  logic          endOpen;
  logic          busy;

  // Controller side: issues commands, observes timer status.
  modport master (
    output StRun, StOpen, delay, close, obstruct,
    input  count, dispStage, endRun, endOpen, busy
  );

  // Timer side: consumes commands, reports status.
  modport slave (
    input  StRun, StOpen, delay, close, obstruct,
    output count, dispStage, endRun, endOpen, busy
  );
endinterface

// File: rtl/elevator_timer.sv
// Unified motion/door timer: internal tick prescaler, floor-transit run
// timing and a door open/hold/close cycle with obstruction reopen,
// saturating hold extension and early-close request.
module elevator_timer #(
  parameter int DIV        = 8,
  parameter int RUN_TICKS  = 6,
  parameter int OPEN_TICKS = 15,
  parameter int EXT_TICKS  = 20,
  parameter int MAX_HOLD   = 100,
  parameter int CW         = 7
) (
  input  logic              CP,
  input  logic              rst,
  elevator_timer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    OPENING = 3'd2,
    HOLD    = 3'd3,
    CLOSING = 3'd4
  } state_t;

  localparam int            PW         = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] RUN_LAST   = CW'(RUN_TICKS - 1);
  localparam logic [CW-1:0] OPEN_LOAD  = CW'(OPEN_TICKS);
  localparam logic [CW-1:0] HOLD_MAX   = CW'(MAX_HOLD);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    stage_q, stage_d;
  logic          end_run_q, end_run_d;
  logic          end_open_q, end_open_d;
  logic          busy_q, busy_d;
  logic          open_prev_q, open_prev_d;
  logic          delay_prev_q, delay_prev_d;
  logic          close_prev_q, close_prev_d;

  logic          open_edge, delay_edge, close_edge;
  logic          hold_frozen, tick;
  logic [31:0]   ext_sum;

  // Input edge detection and tick generation; an obstruction during HOLD
  // suppresses ticks so the remaining hold time is frozen.
  always_comb begin
    open_prev_d  = bus.StOpen;
    delay_prev_d = bus.delay;
    close_prev_d = bus.close;
    open_edge    = bus.StOpen & ~open_prev_q;
    delay_edge   = bus.delay  & ~delay_prev_q;
    close_edge   = bus.close  & ~close_prev_q;
    hold_frozen  = (state_q == HOLD) && bus.obstruct;
    tick         = (state_q != IDLE) && (presc_q == PRESC_LAST) && !hold_frozen;
  end

  // Next-state and registered-output logic. In HOLD a close/delay edge
  // takes precedence over a tick landing in the same cycle.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    stage_d    = stage_q;
    end_run_d  = 1'b0;
    end_open_d = 1'b0;
    ext_sum    = 32'(count_q) + 32'(EXT_TICKS);

    case (state_q)
      IDLE: begin
        count_d = '0;
        stage_d = 2'd0;
        if (open_edge) begin
          state_d = OPENING;
        end else if (bus.StRun) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (tick && (count_q == RUN_LAST)) begin
          count_d   = '0;
          end_run_d = 1'b1;
          if (!bus.StRun) begin
            state_d = IDLE;
          end
        end else if (!bus.StRun) begin
          state_d = IDLE;
          count_d = '0;
        end else if (tick) begin
          count_d = count_q + CW'(1);
        end
      end

      OPENING: begin
        count_d = '0;
        if (tick) begin
          if (stage_q >= 2'd2) begin
            stage_d = 2'd3;
            state_d = HOLD;
            count_d = OPEN_LOAD;
          end else begin
            stage_d = stage_q + 2'd1;
          end
        end
      end

      HOLD: begin
        if (close_edge) begin
          count_d = (count_q > CW'(1)) ? CW'(1) : count_q;
        end else if (delay_edge) begin
          count_d = (ext_sum > 32'(MAX_HOLD)) ? HOLD_MAX : CW'(ext_sum);
        end else if (tick) begin
          if (count_q <= CW'(1)) begin
            count_d = '0;
            state_d = CLOSING;
          end else begin
            count_d = count_q - CW'(1);
          end
        end
      end

      CLOSING: begin
        count_d = '0;
        if (bus.obstruct) begin
          state_d = OPENING;
        end else if (tick) begin
          if (stage_q <= 2'd1) begin
            stage_d    = 2'd0;
            end_open_d = 1'b1;
            state_d    = IDLE;
          end else begin
            stage_d = stage_q - 2'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
        stage_d = 2'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Prescaler restarts on every state change, idles at 0 in IDLE and
  // holds its value while the hold time is frozen.
  always_comb begin
    if ((state_d != state_q) || (state_q == IDLE)) begin
      presc_d = '0;
    end else if (hold_frozen) begin
      presc_d = presc_q;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // State and output registers; edge detectors reload from the live
  // inputs under reset so a held input does not fire afterwards.
  always_ff @(posedge CP) begin
    if (rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      count_q    <= '0;
      stage_q    <= 2'd0;
      end_run_q  <= 1'b0;
      end_open_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      count_q    <= count_d;
      stage_q    <= stage_d;
      end_run_q  <= end_run_d;
      end_open_q <= end_open_d;
      busy_q     <= busy_d;
    end
    open_prev_q  <= open_prev_d;
    delay_prev_q <= delay_prev_d;
    close_prev_q <= close_prev_d;
  end

  assign bus.count     = count_q;
  assign bus.dispStage = stage_q;
  assign bus.endRun    = end_run_q;
  assign bus.endOpen   = end_open_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_elevator_timer.sv
// Testbench for elevator_timer: table-driven short vectors plus
// hand-written run, door, extension, obstruction and reset sequences.
module tb_elevator_timer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  elevator_timer_if #(.CW(7)) bus ();

  elevator_timer #(
    .DIV(4), .RUN_TICKS(6), .OPEN_TICKS(10),
    .EXT_TICKS(20), .MAX_HOLD(60), .CW(7)
  ) dut (
    .CP (clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic rst;
    logic st_run;
    logic st_open;
    logic dly;
    logic cls;
    logic obs;
    int   e_count;
    int   e_stage;
    int   e_end_run;
    int   e_end_open;
    int   e_busy;
  } vec_t;

  vec_t vecs[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input int s,
                         input int er, input int eo, input int b);
    chk($sformatf("%s count", tag),     int'(bus.count),     c);
    chk($sformatf("%s dispStage", tag), int'(bus.dispStage), s);
    chk($sformatf("%s endRun", tag),    int'(bus.endRun),    er);
    chk($sformatf("%s endOpen", tag),   int'(bus.endOpen),   eo);
    chk($sformatf("%s busy", tag),      int'(bus.busy),      b);
  endtask

  task automatic clear_inputs();
    bus.StRun    = 1'b0;
    bus.StOpen   = 1'b0;
    bus.delay    = 1'b0;
    bus.close    = 1'b0;
    bus.obstruct = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    clear_inputs();
    rst = 1'b1;
    step();
    chk_all(tag, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  // Door cycle with no other inputs, cycle n after OPENING entry.
  function automatic int door_stage(input int n);
    if (n < 4)  return 0;
    if (n < 8)  return 1;
    if (n < 12) return 2;
    if (n < 56) return 3;
    if (n < 60) return 2;
    if (n < 64) return 1;
    return 0;
  endfunction

  function automatic int door_count(input int n);
    if (n >= 12 && n < 52) return 10 - (n - 12) / 4;
    return 0;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();
    step();
    step();

    // rst st_run st_open delay close obstruct | count stage endRun endOpen busy
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 13; i++) begin
      rst          = vecs[i].rst;
      bus.StRun    = vecs[i].st_run;
      bus.StOpen   = vecs[i].st_open;
      bus.delay    = vecs[i].dly;
      bus.close    = vecs[i].cls;
      bus.obstruct = vecs[i].obs;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_stage,
              vecs[i].e_end_run, vecs[i].e_end_open, vecs[i].e_busy);
    end
    rst = 1'b0;

    // Continuous run: endRun at 24, 48, 72; count follows floor(n/4) mod 6.
    do_reset("run_rst");
    bus.StRun = 1'b1;
    step();
    chk_all("run n=0", 0, 0, 0, 0, 1);
    for (int n = 1; n <= 75; n++) begin
      step();
      chk_all($sformatf("run n=%0d", n), (n / 4) % 6, 0,
              (n % 24 == 0) ? 1 : 0, 0, 1);
    end

    // Run dropped at cycle 30: IDLE at 31, no later endRun.
    do_reset("drop_rst");
    bus.StRun = 1'b1;
    step();
    for (int n = 1; n <= 30; n++) begin
      step();
      chk($sformatf("drop n=%0d count", n), int'(bus.count), (n / 4) % 6);
    end
    bus.StRun = 1'b0;
    for (int n = 31; n <= 51; n++) begin
      step();
      chk_all($sformatf("drop n=%0d", n), 0, 0, 0, 0, 0);
    end

    // Plain door cycle, endOpen at cycle 64.
    do_reset("door_rst");
    bus.StOpen = 1'b1;
    step();
    bus.StOpen = 1'b0;
    chk_all("door n=0", 0, 0, 0, 0, 1);
    for (int n = 1; n <= 70; n++) begin
      step();
      chk_all($sformatf("door n=%0d", n), door_count(n), door_stage(n), 0,
              (n == 64) ? 1 : 0, (n < 64) ? 1 : 0);
    end

    // Hold extension with saturation, then early close.
    do_reset("ext_rst");
    bus.StOpen = 1'b1;
    step();
    bus.StOpen = 1'b0;
    for (int n = 1; n <= 20; n++) step();
    chk("ext c20", int'(bus.count), 8);
    bus.delay = 1'b1; step(); chk("ext c21", int'(bus.count), 28);
    bus.delay = 1'b0; step(); chk("ext c22", int'(bus.count), 28);
    bus.delay = 1'b1; step(); chk("ext c23", int'(bus.count), 48);
    bus.delay = 1'b0; step(); chk("ext c24", int'(bus.count), 47);
    bus.delay = 1'b1; step(); chk("ext c25 sat", int'(bus.count), 60);
    bus.delay = 1'b0; step(); chk("ext c26", int'(bus.count), 60);
    bus.close = 1'b1; step(); chk("ext c27 close", int'(bus.count), 1);
    bus.close = 1'b0; step();
    chk_all("ext c28 closing", 0, 3, 0, 0, 1);
    for (int n = 29; n <= 40; n++) begin
      step();
      chk_all($sformatf("ext n=%0d", n), 0,
              (n < 32) ? 3 : (n < 36) ? 2 : (n < 40) ? 1 : 0,
              0, (n == 40) ? 1 : 0, (n < 40) ? 1 : 0);
    end

    // Obstruction while closing reopens; obstruction in HOLD freezes count.
    do_reset("obs_rst");
    bus.StOpen = 1'b1;
    step();
    bus.StOpen = 1'b0;
    for (int n = 1; n <= 56; n++) step();
    chk("obs c56 stage", int'(bus.dispStage), 2);
    bus.obstruct = 1'b1;
    step();
    chk_all("obs c57 reopen", 0, 2, 0, 0, 1);
    for (int n = 58; n <= 60; n++) begin
      step();
      chk($sformatf("obs n=%0d stage", n), int'(bus.dispStage), 2);
    end
    step();
    chk_all("obs c61 hold", 10, 3, 0, 0, 1);
    for (int n = 62; n <= 75; n++) begin
      step();
      chk($sformatf("obs n=%0d frozen", n), int'(bus.count), 10);
    end
    bus.obstruct = 1'b0;
    for (int n = 76; n <= 78; n++) begin
      step();
      chk($sformatf("obs n=%0d count", n), int'(bus.count), 10);
    end
    step();
    chk("obs c79 count", int'(bus.count), 9);

    // Reset mid-HOLD with StOpen held across reset release.
    do_reset("mid_rst");
    bus.StOpen = 1'b1;
    step();
    bus.StOpen = 1'b0;
    for (int n = 1; n <= 20; n++) step();
    chk("mid c20 count", int'(bus.count), 8);
    bus.StOpen = 1'b1;
    rst = 1'b1;
    step();
    chk_all("mid reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      step();
      chk_all($sformatf("held n=%0d", n), 0, 0, 0, 0, 0);
    end
    bus.StOpen = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_timer.md
Name: elevator_timer

Overview:
- Unified, parametrised motion/door timer for the elevator controller.
- Replaces the separate run timer, door timer and clock divider with one single-clock block.
- Contains an internal tick prescaler, so no derived clocks are needed.
- Adds behaviour the earlier timers lacked:
  - door-obstruction reopen;
  - saturating hold extension;
  - close-early request;
  - continuous floor-to-floor run;
  - explicit synchronous reset.

Parameters:
- DIV, 8: CP cycles per timer tick (≥2).
- RUN_TICKS, 6: ticks per floor transit (≥1).
- OPEN_TICKS, 15: initial door-hold ticks (≥1).
- EXT_TICKS, 20: ticks added per delay request.
- MAX_HOLD, 100: saturation limit for remaining hold ticks.
- CW, 7: width of count; must hold max(RUN_TICKS, MAX_HOLD).

Ports:
- CP  in  1  system clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- StRun  in  1  level: move to the next floor(s) while high.
- StOpen  in  1  rising edge starts a door cycle.
- delay  in  1  rising edge extends the hold.
- close  in  1  rising edge requests early close.
- obstruct  in  1  level: something is in the doorway.
- count  out  CW  ticks elapsed in RUN; remaining ticks in HOLD; 0 otherwise.
- dispStage  out  2  door opening amount, 0 = shut, 3 = fully open.
- endRun  out  1  one-cycle pulse per completed floor transit.
- endOpen  out  1  one-cycle pulse when the door is fully shut again.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset, sampled at an edge with rst=1:
  - state IDLE; count, dispStage, endRun, endOpen, busy all 0;
  - prescaler 0; edge-detect registers take the current input values, so a held input does not fire after reset;
  - reset overrides everything, including mid-RUN and mid-door operation.
- Prescaler:
  - cleared to 0 on every state change;
  - counts 0..DIV-1 while not IDLE;
  - tick is asserted when prescaler==DIV-1;
  - the Nth tick after state entry (entry cycle = 0) occurs at cycle N·DIV-1.
- All outputs are registered; an output caused by a tick is visible one cycle later.
- IDLE:
  - StOpen rising edge → OPENING;
  - otherwise StRun=1 → RUN;
  - a StOpen edge wins when both start conditions are present in the same cycle.
- RUN:
  - count increments on each tick;
  - on the tick where count==RUN_TICKS-1: count←0, endRun pulses;
  - then stay in RUN if StRun=1, else go to IDLE;
  - StRun=0 at any other time → IDLE next cycle, count←0, no endRun;
  - a StOpen edge in RUN is ignored.
- OPENING:
  - dispStage increments by 1 per tick;
  - on the tick where dispStage becomes 3 → HOLD, count←OPEN_TICKS.
- HOLD:
  - count decrements per tick;
  - reaching 0 → CLOSING;
  - delay edge: count←min(count+EXT_TICKS, MAX_HOLD), with no wrap;
  - close edge: count←min(count,1);
  - if delay and close edges coincide, close wins;
  - obstruct=1 freezes count and holds off ticks until it drops.
- CLOSING:
  - dispStage decrements by 1 per tick;
  - obstruct=1 at any cycle → OPENING immediately, continuing from the current dispStage;
  - on the tick where dispStage reaches 0: endOpen pulses, → IDLE.
- Input edges (StOpen, delay, close) are detected against the previous-cycle sample.
- Edges of delay and close outside HOLD are discarded.
- endRun and endOpen are never high for more than 1 cycle.
- count and dispStage never wrap.

Test Plan (DIV=4, RUN_TICKS=6, OPEN_TICKS=10, EXT_TICKS=20, MAX_HOLD=60):
- Run: StRun high from reset release → endRun pulses at cycles 24, 48, 72 after RUN entry, and count sequences 0..5. Dropping StRun at cycle 30 → IDLE at cycle 31, count=0, no further endRun.
- Door cycle: StOpen edge, no other inputs:
  - dispStage rises 1, 2, 3 at cycles 4, 8, 12;
  - HOLD spans 10 ticks;
  - dispStage falls 2, 1, 0;
  - endOpen is a single pulse at cycle 64 after OPENING entry.
- Extension: in HOLD at count=8, issue delay ×3 → count 28, 48, 60 (saturated). Then a close edge → count=1, and CLOSING is entered on the next tick.
- Obstruction: obstruct=1 while CLOSING at dispStage=2 → OPENING the next cycle, stage 3 at the next tick, HOLD reloaded to 10. obstruct=1 throughout HOLD → count frozen.
- Priority and reset:
  - StRun and StOpen edge in the same cycle → OPENING;
  - rst=1 mid-HOLD → all outputs 0 next cycle;
  - after reset release, a StOpen held high since before reset does not start a door cycle.
